// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target write receiver.
// Holds the FSM state encoding and the address and byte widths.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam logic [3:0] BIT_CNT_MAX = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        HOLD,
        DATA_ACK
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one open-drain bus line, with registered edge strobes.
// All flops reset to 1 so that a released bus produces no edge when reset ends.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= line_in;
            sync_p1 <= sync_p0;
            // edge register: strobes and level below stay aligned to the same sample
            prev_p2 <= sync_p1;
            rise    <= sync_p1 & ~prev_p2;
            fall    <= ~sync_p1 & prev_p2;
        end
    end

    assign level = prev_p2;

endmodule

// File: rtl/i2c_target_rx.sv
// Clock-stretching I2C target write receiver: START/STOP detection, 7-bit address
// match, byte reception, and an SCL hold until the consumer accepts each byte.
module i2c_target_rx #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_hold,
    output logic       sda_pull,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy
);

    import i2c_pkg::*;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_e              state, state_nxt;
    logic [3:0]              bit_cnt, bit_cnt_nxt;
    logic [I2C_BYTE_W-1:0]   shift, shift_nxt;
    logic [I2C_BYTE_W-1:0]   rx_data_nxt;
    logic                    rx_valid_nxt, scl_hold_nxt, sda_pull_nxt, busy_nxt;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            scl_hold <= 1'b0;
            sda_pull <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            scl_hold <= scl_hold_nxt;
            sda_pull <= sda_pull_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = rx_valid;
        scl_hold_nxt = scl_hold;
        sda_pull_nxt = sda_pull;
        busy_nxt     = busy;

        if ((start_det || stop_det) && scl_hold) begin
            // bus error: the master cannot legally signal while SCL is held
            state_nxt    = IDLE;
            bit_cnt_nxt  = 4'd0;
            rx_data_nxt  = '0;
            rx_valid_nxt = 1'b0;
            scl_hold_nxt = 1'b0;
            sda_pull_nxt = 1'b0;
            busy_nxt     = 1'b0;
        end else if (stop_det) begin
            state_nxt    = IDLE;
            bit_cnt_nxt  = 4'd0;
            rx_valid_nxt = 1'b0;
            scl_hold_nxt = 1'b0;
            sda_pull_nxt = 1'b0;
            busy_nxt     = 1'b0;
        end else if (start_det) begin
            // i2c_pkg:: scope needed: the module parameter ADDR hides the state name
            state_nxt    = i2c_pkg::ADDR;
            bit_cnt_nxt  = 4'd0;
            rx_valid_nxt = 1'b0;
            scl_hold_nxt = 1'b0;
            sda_pull_nxt = 1'b0;
            busy_nxt     = 1'b1;
        end else begin
            case (state)
                i2c_pkg::ADDR, DATA: begin
                    if (scl_rise && bit_cnt < BIT_CNT_MAX) begin
                        shift_nxt   = {shift[I2C_BYTE_W-2:0], sda_lvl};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == BIT_CNT_MAX) begin
                        if (state == DATA) begin
                            rx_data_nxt  = shift;
                            rx_valid_nxt = 1'b1;
                            scl_hold_nxt = 1'b1;
                            state_nxt    = HOLD;
                        end else if (shift[I2C_BYTE_W-1:I2C_BYTE_W-I2C_ADDR_W] == ADDR
                                     && !shift[0]) begin
                            sda_pull_nxt = 1'b1;
                            state_nxt    = ADDR_ACK;
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_pull_nxt = 1'b0;
                        bit_cnt_nxt  = 4'd0;
                        state_nxt    = DATA;
                    end
                end
                HOLD: begin
                    // ACK goes out while SCL is still held, giving SDA setup before release
                    if (rx_valid && rx_ready) begin
                        rx_valid_nxt = 1'b0;
                        sda_pull_nxt = 1'b1;
                        state_nxt    = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    scl_hold_nxt = 1'b0;
                    if (scl_fall) begin
                        sda_pull_nxt = 1'b0;
                        bit_cnt_nxt  = 4'd0;
                        state_nxt    = DATA;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Clock-stretching I2C target (slave) write receiver. It samples the open-drain SCL/SDA lines, detects START/STOP, matches a 7-bit address and accepts write bytes. After each data byte it holds SCL low until the local consumer takes the byte over a valid/ready handshake. It sits on the bus opposite the existing master clock generator, and its SCL hold is the stretch that the master honours.

## Interface
- ADDR, 7'h42, 7-bit target address this block answers to
- clk  input  1  system clock; SCL/SDA are asynchronous to it
- rst  input  1  synchronous, active-high reset
- scl_in  input  1  sensed SCL line level
- sda_in  input  1  sensed SDA line level
- scl_hold  output  1  1 = drive SCL low (stretch); 0 = release
- sda_pull  output  1  1 = drive SDA low (ACK); 0 = release
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready
- busy  output  1  1 from START until STOP or abort

## Operation
- SCL and SDA each pass through a 2-flop synchroniser plus a previous-value register. Rise and fall strobes come from the synchronised value.
- START: SDA fall while synchronised SCL = 1. STOP: SDA rise while SCL = 1.
- Data bits are sampled MSB-first on the SCL rise strobe.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits (7 address bits, then R/W).
  - ADDR_ACK
  - DATA: shifts 8 bits.
  - HOLD
  - DATA_ACK
- ADDR, after the 8th bit's SCL fall:
  - Address == ADDR and R/W = 0: sda_pull=1, go to ADDR_ACK.
  - Otherwise (mismatch, or read): sda_pull stays 0 (NACK). Go to IDLE with busy=0. Ignore the bus until the next START.
- ADDR_ACK: on the next SCL fall, sda_pull=0 and go to DATA with bit count 0.
- DATA, on the 8th bit's SCL fall:
  - rx_data=shift register, rx_valid=1, scl_hold=1.
  - Go to HOLD.
- HOLD: when rx_valid & rx_ready:
  - rx_valid=0, sda_pull=1 (ACK driven while SCL is held).
  - scl_hold=0 on the following cycle.
  - Go to DATA_ACK.
- DATA_ACK: on the next SCL fall, sda_pull=0, go to DATA with count 0.
- START in any state other than IDLE is a repeated start: go to ADDR with count 0. sda_pull, scl_hold and rx_valid are cleared.
- STOP in any state: go to IDLE. All outputs are cleared, except rx_data, which holds.
- START or STOP detected while scl_hold=1 is a bus error: abort to IDLE with all outputs cleared.
- The shift register and bit counter are 8-bit and 4-bit. The counter saturates at 8 and never wraps.
- No overrun is possible: the master cannot clock a new byte while SCL is held.

## Timing
- Reset values:
  - State IDLE.
  - scl_hold=0, sda_pull=0, rx_valid=0, busy=0, rx_data=8'h00.
  - Synchronisers set to 1, so a released bus produces no false edges.
- All outputs are registered.
- Line event to strobe: 3 clk (2 synchroniser stages + edge register).
- Strobe to output change: +1 clk.
- Handshake to SCL release: rx_valid falls 1 clk after a handshake cycle; scl_hold falls 1 clk after that.
  - Gives ≥1 clk of SDA setup before SCL can rise.
- rx_ready asserted before rx_valid has no effect.
- busy rises 1 clk after the START strobe.
- rst mid-transaction: all outputs at reset values on the next edge, regardless of bus state.

## Structure
- Package i2c_pkg holds:
  - State enum: IDLE, ADDR, ADDR_ACK, DATA, HOLD, DATA_ACK.
  - I2C_ADDR_W=7.
  - I2C_BYTE_W=8.
- Sub-module i2c_line_sync: 2-flop synchroniser with rise/fall strobes, reset-to-1. Instantiated once for SCL and once for SDA.
- FSM, shift register and counters live in i2c_target_rx.

## Test plan
- START, address 0x42+W, byte 0xA5, rx_ready held 1, STOP:
  - ACK low during both 9th clocks.
  - rx_data=0xA5.
  - rx_valid pulses 1 clk.
  - busy falls after STOP.
- Address 0x43+W:
  - SDA never pulled.
  - busy=0 after the 8th SCL fall.
  - A following byte 0xFF produces no rx_valid.
- Address 0x42+R: NACK, return to IDLE, no rx_valid.
- Byte 0x3C, rx_ready held 0 for 50 clk:
  - scl_hold=1 throughout and rx_data stable.
  - After rx_ready=1: sda_pull=1 first, then scl_hold=0 the next clk.
- Two bytes 0x11, 0x22 with repeated START between address phases:
  - Both delivered in order.
  - Second address phase ACKed.
- rst asserted mid-DATA (bit 4): all outputs 0 next clk, and no byte is delivered until a fresh START.
